modport_ram: RTL and testbench
==============================

// Module: modport_ram
// PURPOSE
//  32x8 RAM with independent read and write enables sharing one address bus.
//  Synchronous write, registered synchronous read (1-cycle latency).
//  Leaf storage block; driven by a driver-side clocking block.
//  Observed by input and output monitors on the same clock.
// PARAMETERS
//  DATA_WIDTH  8   bits per word (ports are [DATA_WIDTH-1:0])
//  ADDR_WIDTH  5   address bits (ports are [ADDR_WIDTH-1:0])
//  DEPTH       32  words, = 2**ADDR_WIDTH (derived, not overridable)
// PORTS
//  clk       in   1           sole clock; all activity on posedge
//  rst       in   1           reset: synchronous, active-high
//  wr_en     in   1           write strobe; sampled at posedge
//  rd_en     in   1           read strobe; sampled at posedge
//  addr      in   ADDR_WIDTH  word address for the read and/or write
//  data_in   in   DATA_WIDTH  write data
//  data_out  out  DATA_WIDTH  registered read data
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - all DEPTH words cleared to 0; data_out <= 0.
//    - rd_en/wr_en ignored that cycle; reset wins over any enable.
//  - Write: posedge with wr_en=1, rst=0 -> mem[addr] <= data_in.
//  - Read: posedge with rd_en=1, rst=0 -> data_out <= mem[addr].
//    - Visible the cycle after the sampling edge.
//  - rd_en=0: data_out holds its last value; never returns to 0 except by rst.
//  - rd_en=1 and wr_en=1 on the same edge (same addr by construction):
//    - default: read-before-write; data_out gets the OLD mem[addr].
//    - the write still completes on that edge.
//  - Back-to-back writes or reads, one per cycle: no bubbles, no stalls, no handshake.
//  - Every address 0..31 is valid; no out-of-range case exists.
//  - Addr 31 -> 0 needs no special handling.
//  - No X on data_out after the first reset.
//  - Behaviour before the first reset is undefined.
// CONFIGURATION
//  `MODPORT_RAM_WRITE_FIRST_EN
//    - defined: simultaneous rd_en & wr_en returns data_in on data_out
//      (write-first bypass); memory update is unchanged.
//    - undefined: read-before-write, as above.
//  The macro changes only the simultaneous rd_en & wr_en case; all other timing is identical.
// STRUCTURE
//  - Package modport_ram_pkg:
//    - DATA_WIDTH, ADDR_WIDTH, DEPTH localparams.
//    - typedef logic [DATA_WIDTH-1:0] data_t.
//    - typedef logic [ADDR_WIDTH-1:0] addr_t.
//  - Sub-module modport_ram_array: storage array only.
//    - Inputs: clk, rst, we, addr, wdata; output: async rdata.
//    - Reset clear of all DEPTH words lives here.
//  - Top (modport_ram):
//    - Instantiates modport_ram_array.
//    - Owns the data_out register and the read-before-write/bypass mux.
// TESTING
//  1. Reset: rst=1 for 2 cycles, then read addr 0, 17, 31
//     -> data_out=0 one cycle after each rd_en.
//  2. Write/readback: write 0xA5@3, 0x3C@31, 0xFF@0; read 3, 31, 0
//     -> 0xA5, 0x3C, 0xFF, each 1 cycle after rd_en.
//  3. Simultaneous: mem[7]=0x11; rd_en=wr_en=1, addr=7, data_in=0x22
//     -> data_out=0x11 (0x22 with WRITE_FIRST_EN); next read of 7 -> 0x22.
//  4. Hold: read 0x5A from addr 9, then rd_en=0 for 5 cycles with writes elsewhere
//     -> data_out stays 0x5A.
//  5. Mid-op reset: fill all 32 words with addr^0x80; assert rst together with wr_en
//     (addr 4, data 0x99) -> data_out=0; all 32 reads return 0.
//  6. Full sweep: write and read all 32 addresses back to back
//     -> zero mismatches, one result per cycle.

Source files
------------

// File: rtl/modport_ram_pkg.sv
// +------------------------------------------------------------------+
// | modport_ram_pkg : shared sizes and word/address types for the RAM |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package modport_ram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
endpackage

`default_nettype wire

// File: rtl/modport_ram_array.sv
// +------------------------------------------------------------------+
// | modport_ram_array : DEPTH x DATA_WIDTH storage, sync write,        |
// | combinational read, synchronous clear of every word on rst.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module modport_ram_array
  import modport_ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t addr,
  input  data_t wdata,
  output data_t rdata
);

  data_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  // Pre-edge contents: the top registers this, giving read-before-write.
  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/modport_ram.sv
// +------------------------------------------------------------------+
// | modport_ram : 32x8 RAM, shared address, registered 1-cycle read.  |
// | Option: MODPORT_RAM_WRITE_FIRST_EN selects write-first bypass.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module modport_ram
  import modport_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  data_t w_rdata;
  data_t w_rd_next;
  data_t r_data_out;

  modport_ram_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .addr  (addr),
    .wdata (data_in),
    .rdata (w_rdata)
  );

`ifdef MODPORT_RAM_WRITE_FIRST_EN
  assign w_rd_next = wr_en ? data_in : w_rdata;
`else
  assign w_rd_next = w_rdata;
`endif

  // Output only moves on a read or reset; otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (rd_en) begin
      r_data_out <= w_rd_next;
    end
  end

  assign data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_modport_ram.sv
// +------------------------------------------------------------------+
// | tb_modport_ram : table vectors plus scoreboarded corner sequences |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_modport_ram;
  import modport_ram_pkg::*;

`ifdef MODPORT_RAM_WRITE_FIRST_EN
  localparam bit WF = 1'b1;
`else
  localparam bit WF = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  wr_en = 1'b0;
  logic  rd_en = 1'b0;
  addr_t addr = '0;
  data_t data_in = '0;
  data_t data_out;

  modport_ram dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    data_t exp;
    string tag;
  } sb_t;

  typedef struct {
    logic  r;
    logic  w;
    logic  rd;
    addr_t a;
    data_t d;
    data_t exp;
  } vec_t;

  sb_t   sb_q[$];
  data_t m_mem [DEPTH];
  data_t m_out;
  int    n_checks = 0;
  int    n_errors = 0;

  // Each driven cycle queues the value data_out must show after that edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (data_out !== e.exp) begin
        n_errors++;
        $display("FAIL %s: data_out=%h expected=%h", e.tag, data_out, e.exp);
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic rd,
                      input addr_t a, input data_t d,
                      input bit use_exp, input data_t exp_in, input string tag);
    sb_t e;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; addr = a; data_in = d;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_out = '0;
    end else begin
      if (rd) m_out = (w && WF) ? d : m_mem[a];
      if (w)  m_mem[a] = d;
    end
    e.exp = use_exp ? exp_in : m_out;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic run(input logic r, input logic w, input logic rd,
                     input addr_t a, input data_t d, input string tag);
    step(r, w, rd, a, d, 1'b0, '0, tag);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1, 0, 0, 5'd0,  8'h00, 8'h00};
    tbl[1]  = '{1, 0, 0, 5'd0,  8'h00, 8'h00};
    tbl[2]  = '{0, 0, 1, 5'd0,  8'h00, 8'h00};
    tbl[3]  = '{0, 0, 1, 5'd17, 8'h00, 8'h00};
    tbl[4]  = '{0, 0, 1, 5'd31, 8'h00, 8'h00};
    tbl[5]  = '{0, 1, 0, 5'd3,  8'hA5, 8'h00};
    tbl[6]  = '{0, 1, 0, 5'd31, 8'h3C, 8'h00};
    tbl[7]  = '{0, 1, 0, 5'd0,  8'hFF, 8'h00};
    tbl[8]  = '{0, 0, 1, 5'd3,  8'h00, 8'hA5};
    tbl[9]  = '{0, 0, 1, 5'd31, 8'h00, 8'h3C};
    tbl[10] = '{0, 0, 1, 5'd0,  8'h00, 8'hFF};
    tbl[11] = '{0, 1, 0, 5'd7,  8'h11, 8'hFF};
    tbl[12] = '{0, 1, 1, 5'd7,  8'h22, WF ? 8'h22 : 8'h11};
    tbl[13] = '{0, 0, 1, 5'd7,  8'h00, 8'h22};
    tbl[14] = '{0, 0, 0, 5'd7,  8'h00, 8'h22};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].a, tbl[i].d,
           1'b1, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Hold: output must not move while rd_en is low, even with writes.
    run(0, 1, 0, 5'd9, 8'h5A, "hold_wr");
    run(0, 0, 1, 5'd9, 8'h00, "hold_rd");
    for (int i = 0; i < 5; i++) begin
      run(0, 1, 0, addr_t'(10 + i), data_t'(8'hC0 + i), $sformatf("hold%0d", i));
    end

    // Mid-op reset: reset must beat the concurrent write.
    for (int i = 0; i < DEPTH; i++) begin
      run(0, 1, 0, addr_t'(i), data_t'(i ^ 8'h80), $sformatf("fill%0d", i));
    end
    run(0, 0, 1, 5'd5, 8'h00, "fill_chk");
    run(1, 1, 0, 5'd4, 8'h99, "rst_wr");
    for (int i = 0; i < DEPTH; i++) begin
      run(0, 0, 1, addr_t'(i), 8'h00, $sformatf("clr%0d", i));
    end

    // Back-to-back sweep, including the 31 -> 0 wrap.
    for (int i = 0; i < DEPTH; i++) begin
      run(0, 1, 0, addr_t'(i), data_t'($urandom_range(0, 255)), $sformatf("sw_w%0d", i));
    end
    for (int i = 0; i < DEPTH; i++) begin
      run(0, 0, 1, addr_t'((i + 20) % DEPTH), 8'h00, $sformatf("sw_r%0d", i));
    end
    run(0, 0, 0, 5'd0, 8'h00, "idle");

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
